// File: rtl/timer_sequencer.sv
// Prescaler/counter sequencer: latches a divisor and terminal count, runs them under
// start/stop/pause commands and pulses done_pulse one cycle after the terminal tick.
module timer_sequencer #(
    parameter int CTR_WIDTH = 24,
    parameter int PRE_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [PRE_WIDTH-1:0] cfg_prescale,
    input  logic [CTR_WIDTH-1:0] cfg_limit,
    input  logic                 cfg_periodic,
    input  logic                 cmd_start,
    input  logic                 cmd_stop,
    input  logic                 cmd_pause,
    output logic [CTR_WIDTH-1:0] count,
    output logic                 done_pulse,
    output logic                 busy,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CTR_WIDTH-1:0] r_count;
    logic [CTR_WIDTH-1:0] w_count_nxt;
    logic [PRE_WIDTH-1:0] r_prescaler;
    logic [PRE_WIDTH-1:0] w_prescaler_nxt;
    logic [PRE_WIDTH-1:0] r_prescale_reg;
    logic [CTR_WIDTH-1:0] r_limit_reg;
    logic                 r_periodic_reg;
    logic                 r_done_pulse;
    logic                 w_done_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;

    logic w_in_run;
    logic w_idle_or_done;
    logic w_pause_go;
    logic w_advance;
    logic w_tick;
    logic w_terminal;
    logic w_restart;

    assign w_in_run       = (r_state == S_RUN);
    assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);

    // Start outranks pause, so a start held in RUN (itself ignored) also masks pause.
    assign w_pause_go = w_in_run && !cmd_stop && !cmd_start && cmd_pause;
    assign w_advance  = w_in_run && !cmd_stop && !w_pause_go;
    assign w_tick     = w_advance && (r_prescaler == r_prescale_reg);
    assign w_terminal = w_tick && (r_count == r_limit_reg);
    assign w_restart  = !cmd_stop && cmd_start && w_idle_or_done;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (cmd_stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (cmd_start) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_pause_go) begin
                        w_state_nxt = S_PAUSE;
                    end else if (w_terminal && !r_periodic_reg) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_PAUSE: begin
                    if (cmd_start) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath / output next values
    always_comb begin
        w_count_nxt     = r_count;
        w_prescaler_nxt = r_prescaler;
        w_done_nxt      = 1'b0;
        w_busy_nxt      = (w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSE);
        if (cmd_stop || w_restart) begin
            w_count_nxt     = '0;
            w_prescaler_nxt = '0;
        end else if (w_advance) begin
            if (w_tick) begin
                w_prescaler_nxt = '0;
                if (w_terminal) begin
                    w_done_nxt = 1'b1;
                    // One-shot holds at the limit; periodic wraps to zero.
                    w_count_nxt = r_periodic_reg ? '0 : r_count;
                end else begin
                    w_count_nxt = r_count + CTR_WIDTH'(1);
                end
            end else begin
                w_prescaler_nxt = r_prescaler + PRE_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count      <= '0;
            r_prescaler  <= '0;
            r_done_pulse <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_count      <= w_count_nxt;
            r_prescaler  <= w_prescaler_nxt;
            r_done_pulse <= w_done_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    // Configuration is only writable while the datapath is not running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescale_reg <= '0;
            r_limit_reg    <= '0;
            r_periodic_reg <= 1'b0;
        end else if (cfg_we && w_idle_or_done) begin
            r_prescale_reg <= cfg_prescale;
            r_limit_reg    <= cfg_limit;
            r_periodic_reg <= cfg_periodic;
        end
    end

    assign count      = r_count;
    assign done_pulse = r_done_pulse;
    assign busy       = r_busy;
    assign state      = r_state;

endmodule

// File: tb/tb_timer_sequencer.sv
// Scenario bench for timer_sequencer: expected {busy, done_pulse, state, count} words
// are queued as stimulus is applied and compared one cycle later.
module tb_timer_sequencer;
  localparam int CW = 24;
  localparam int PW = 16;
  localparam int W  = CW + 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [PW-1:0] cfg_prescale = '0;
  logic [CW-1:0] cfg_limit = '0;
  logic          cfg_periodic = 1'b0;
  logic          cmd_start = 1'b0;
  logic          cmd_stop = 1'b0;
  logic          cmd_pause = 1'b0;
  logic [CW-1:0] count;
  logic          done_pulse;
  logic          busy;
  logic [1:0]    state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  logic [W-1:0] obs;
  int total = 0;
  int bad = 0;

  assign obs = {busy, done_pulse, state, count};

  always #5 clk = ~clk;

  timer_sequencer #(.CTR_WIDTH(CW), .PRE_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_prescale(cfg_prescale),
    .cfg_limit(cfg_limit), .cfg_periodic(cfg_periodic), .cmd_start(cmd_start),
    .cmd_stop(cmd_stop), .cmd_pause(cmd_pause), .count(count),
    .done_pulse(done_pulse), .busy(busy), .state(state)
  );

  // expected word: busy is implied by the state (RUN or PAUSE)
  function automatic logic [W-1:0] pk(input int c, input int s, input bit d);
    logic [1:0] s2;
    logic [CW-1:0] c2;
    s2 = s[1:0];
    c2 = c[CW-1:0];
    return {(s2 == 2'd1) || (s2 == 2'd2), d, s2, c2};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int pre, input int lim, input bit per);
    cfg_prescale = pre[PW-1:0];
    cfg_limit    = lim[CW-1:0];
    cfg_periodic = per;
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    exp_q.push_back(pk(0, 0, 0));
    step();
    exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset got=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_oneshot();
    cfg(1, 4, 0);
    cmd_start = 1'b1;
    exp_q.push_back(pk(0, 1, 0));
    step();
    cmd_start = 1'b0;
    exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL oneshot_entry got=%h exp=%h", obs, exp_v); end
    for (int k = 1; k <= 14; k++) begin
      if (k < 10) exp_q.push_back(pk(k / 2, 1, 0));
      else if (k == 10) exp_q.push_back(pk(4, 3, 1));
      else exp_q.push_back(pk(4, 3, 0));
      step();
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL oneshot k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
  endtask

  task automatic test_periodic();
    cfg(0, 2, 1);
    cmd_start = 1'b1;
    exp_q.push_back(pk(0, 1, 0));
    step();
    cmd_start = 1'b0;
    exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL periodic_entry got=%h exp=%h", obs, exp_v); end
    for (int k = 1; k <= 12; k++) begin
      cmd_start = (k == 5);  // start while running must be ignored
      exp_q.push_back(pk(k % 3, 1, (k % 3) == 0));
      step();
      cmd_start = 1'b0;
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL periodic k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
    cmd_stop = 1'b1;
    exp_q.push_back(pk(0, 0, 0));
    step();
    cmd_stop = 1'b0;
    exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL periodic_stop got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_pause();
    cfg(3, 100, 0);
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    for (int k = 1; k <= 21; k++) exp_q.push_back(pk(k / 4, 1, 0));
    cmd_pause = 1'b1;
    exp_q.push_back(pk(5, 2, 0));
    for (int k = 1; k <= 20; k++) exp_q.push_back(pk(5, 2, 0));
    exp_q.push_back(pk(5, 1, 0));
    for (int j = 1; j <= 8; j++) exp_q.push_back(pk((21 + j) / 4, 1, 0));
    cmd_pause = 1'b0;
    for (int n = 1; n <= 51; n++) begin
      cmd_pause = (n == 22);
      cmd_start = (n == 43);
      step();
      cmd_pause = 1'b0;
      cmd_start = 1'b0;
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL pause n=%0d got=%h exp=%h", n, obs, exp_v); end
    end
    cmd_stop = 1'b1;
    step();
    cmd_stop = 1'b0;
  endtask

  task automatic test_lockout();
    cfg(0, 3, 0);
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 2) begin
        cfg_prescale = 16'd5;
        cfg_limit    = 24'd1;
        cfg_periodic = 1'b1;
        cfg_we       = 1'b1;
      end
      if (k < 4) exp_q.push_back(pk(k, 1, 0));
      else exp_q.push_back(pk(3, 3, k == 4));
      step();
      cfg_we = 1'b0;
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL lockout_run k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
    exp_q.push_back(pk(3, 3, 0));
    cfg(0, 1, 0);
    exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL lockout_cfg got=%h exp=%h", obs, exp_v); end
    cmd_start = 1'b1;
    exp_q.push_back(pk(0, 1, 0));
    exp_q.push_back(pk(1, 1, 0));
    exp_q.push_back(pk(1, 3, 1));
    exp_q.push_back(pk(1, 3, 0));
    for (int k = 0; k <= 3; k++) begin
      step();
      cmd_start = 1'b0;
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL lockout_done k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
  endtask

  task automatic test_stop_terminal();
    cfg(1, 2, 0);
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      cmd_stop = (k == 6);  // edge 6 is the terminal tick
      if (k < 6) exp_q.push_back(pk(k / 2, 1, 0));
      else exp_q.push_back(pk(0, 0, 0));
      step();
      cmd_stop = 1'b0;
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL stop_terminal k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
  endtask

  task automatic test_start_pause();
    cfg(1, 100, 0);
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      cmd_pause = (n == 6) || (n == 10);
      cmd_start = (n == 10);
      if (n <= 5) exp_q.push_back(pk(n / 2, 1, 0));
      else if (n <= 9) exp_q.push_back(pk(2, 2, 0));
      else if (n == 10) exp_q.push_back(pk(2, 1, 0));
      else exp_q.push_back(pk((n - 5) / 2, 1, 0));
      step();
      cmd_pause = 1'b0;
      cmd_start = 1'b0;
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL start_pause n=%0d got=%h exp=%h", n, obs, exp_v); end
    end
    cmd_stop = 1'b1;
    step();
    cmd_stop = 1'b0;
  endtask

  task automatic test_back_to_back();
    cfg(0, 0, 1);
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      cmd_stop = (k == 9);
      if (k < 9) exp_q.push_back(pk(0, 1, 1));
      else exp_q.push_back(pk(0, 0, 0));
      step();
      cmd_stop = 1'b0;
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL back_to_back k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
  endtask

  task automatic test_reset_midrun();
    cfg(3, 9, 0);
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    for (int k = 1; k <= 17; k++) exp_q.push_back(pk(k / 4, 1, 0));
    for (int k = 1; k <= 17; k++) begin
      step();
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL midrun k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_v = pk(0, 0, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL async_reset got=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    rst_n = 1'b1;
    // config registers were cleared: prescale=0, limit=0, one-shot
    cmd_start = 1'b1;
    exp_q.push_back(pk(0, 1, 0));
    exp_q.push_back(pk(0, 3, 1));
    exp_q.push_back(pk(0, 3, 0));
    for (int k = 0; k <= 2; k++) begin
      step();
      cmd_start = 1'b0;
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL post_reset k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_lockout();
    test_stop_terminal();
    test_start_pause();
    test_back_to_back();
    test_reset_midrun();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expectations got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
